// File: rtl/watchdog_timer.sv
// Watchdog timer: IDLE/RUN/EXPIRED with kick-to-restart and sticky expiry.
// Optional pre-expiry warning enabled by defining WATCHDOG_WARN_EN.
module watchdog_timer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 20,
  parameter int unsigned WARN_MARGIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kick,
  input  logic             stop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             warn
);

  typedef enum logic [1:0] {StIdle, StRun, StExpired} state_e;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LastCnt    = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 2 || (TIMEOUT >> CNT_W) != 0 || WARN_MARGIN < 1 || WARN_MARGIN >= TIMEOUT)
  begin : g_param_chk
    $error("watchdog_timer: TIMEOUT/WARN_MARGIN out of legal range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        count_d = '0;
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
          count_d = '0;
        end else if (kick) begin
          count_d = '0;
        end else if (count_q == LastCnt) begin
          state_d = StExpired;
          count_d = TimeoutCnt;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      StExpired: begin
        // Count pinned at TIMEOUT; only clear leaves this state.
        count_d = TimeoutCnt;
        if (clear) begin
          state_d = StIdle;
          count_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  assign count   = count_q;
  assign running = (state_q == StRun);
  assign expired = (state_q == StExpired);

`ifdef WATCHDOG_WARN_EN
  localparam logic [CNT_W-1:0] WarnThr = CNT_W'(TIMEOUT - WARN_MARGIN);
  assign warn = (state_q == StRun) && (count_q >= WarnThr);
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_watchdog_timer.sv
// Self-checking bench for watchdog_timer: elapsed-time reference model feeding a scoreboard
// queue, directed scenarios followed by randomized stimulus and asynchronous resets.
module tb_watchdog_timer;

  localparam int CNT_W       = 16;
  localparam int TIMEOUT     = 20;
  localparam int WARN_MARGIN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, kick, stop, clear;
  logic [CNT_W-1:0] count;
  logic             running, expired, warn;

  watchdog_timer #(
    .CNT_W       (CNT_W),
    .TIMEOUT     (TIMEOUT),
    .WARN_MARGIN (WARN_MARGIN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .kick    (kick),
    .stop    (stop),
    .clear   (clear),
    .count   (count),
    .running (running),
    .expired (expired),
    .warn    (warn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             exp;
    logic             wrn;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: time since last start/kick, measured in clock edges.
  int n_edge   = 0;
  int ref_edge = 0;
  bit m_armed  = 0;
  bit m_trip   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic model_step(input logic s, input logic k, input logic p, input logic c);
    n_edge++;
    if (m_trip) begin
      if (c) m_trip = 0;
    end else if (m_armed) begin
      if (p) m_armed = 0;
      else if (k) ref_edge = n_edge;
      else if (n_edge - ref_edge >= TIMEOUT) begin
        m_trip  = 1;
        m_armed = 0;
      end
    end else if (s) begin
      m_armed  = 1;
      ref_edge = n_edge;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int   c;
    c     = m_trip ? TIMEOUT : (m_armed ? n_edge - ref_edge : 0);
    e.cnt = CNT_W'(c);
    e.run = m_armed;
    e.exp = m_trip;
`ifdef WATCHDOG_WARN_EN
    e.wrn = m_armed && (c >= TIMEOUT - WARN_MARGIN);
`else
    e.wrn = 1'b0;
`endif
    return e;
  endfunction

  // One clock of stimulus: drive on the falling edge, queue what the next rising edge yields.
  task automatic cyc(input logic s, input logic k, input logic p, input logic c);
    @(negedge clk);
    start = s;
    kick  = k;
    stop  = p;
    clear = c;
    model_step(s, k, p, c);
    exp_q.push_back(model_out());
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".count"},   32'(count), 0);
    check({tag, ".running"}, 32'(running), 0);
    check({tag, ".expired"}, 32'(expired), 0);
    check({tag, ".warn"},    32'(warn), 0);
  endtask

  // Reset mid-cycle, well away from any clock edge, with inputs active during reset.
  task automatic async_reset();
    @(negedge clk);
    start = 1'b1;
    kick  = 1'b1;
    stop  = 1'b0;
    clear = 1'b1;
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(negedge clk);
    check_zero("held_rst");
    rst     = 1'b0;
    start   = 1'b0;
    kick    = 1'b0;
    clear   = 1'b0;
    m_armed = 0;
    m_trip  = 0;
  endtask

  // Monitor: outputs are valid every cycle; compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("count",   32'(count),   32'(e.cnt));
        check("running", 32'(running), 32'(e.run));
        check("expired", 32'(expired), 32'(e.exp));
        check("warn",    32'(warn),    32'(e.wrn));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    kick  = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    #3 check_zero("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Free-running expiry, then hold in EXPIRED.
    cyc(1, 0, 0, 0);
    repeat (70) cyc(0, 0, 0, 0);
    // Pulses ignored in EXPIRED, then clear and re-arm.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    repeat (22) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    // Periodic kick every 15 cycles never expires.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 200; i++) cyc(0, (i % 15) == 14, 0, 0);
    cyc(0, 0, 1, 0);

    // Kick at count==TIMEOUT-1, then stop+kick together at count 7.
    cyc(1, 0, 0, 0);
    repeat (TIMEOUT - 1) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    repeat (7) cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 0);

    // Asynchronous reset mid-RUN and in EXPIRED.
    cyc(1, 0, 0, 0);
    repeat (12) cyc(0, 0, 0, 0);
    async_reset();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (25) cyc(0, 0, 0, 0);
    async_reset();
    cyc(1, 0, 0, 0);
    repeat (TIMEOUT + 2) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(299) == 0) async_reset();
      else cyc($urandom_range(3) == 0, $urandom_range(15) == 0,
               $urandom_range(39) == 0, $urandom_range(7) == 0);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/watchdog_timer.md
WATCHDOG_TIMER -- requirements
Module: watchdog_timer

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, counter width in bits.
REQ-002 SHALL provide parameter TIMEOUT, default 20, cycles in RUN without kick before expiry; legal range 2 .. 2^CNT_W-1.
REQ-003 SHALL provide parameter WARN_MARGIN, default 4, cycles before expiry at which warn asserts; legal range 1 .. TIMEOUT-1.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  arm watchdog; sampled in IDLE only.
REQ-008 kick  input  1  restart count; sampled in RUN only.
REQ-009 stop  input  1  disarm; sampled in RUN only.
REQ-010 clear  input  1  acknowledge expiry; sampled in EXPIRED only.
REQ-011 count  output  CNT_W  cycles since last start/kick.
REQ-012 running  output  1  high in RUN.
REQ-013 expired  output  1  high in EXPIRED; sticky.
REQ-014 warn  output  1  pre-expiry warning (see Configuration).

Function
REQ-015 SHALL implement states IDLE, RUN, EXPIRED; all outputs registered or decoded from state/count only, with no input-to-output combinational path.
REQ-016 IDLE: count=0; start=1 -> RUN with count=0 at next edge.
REQ-017 RUN, priority stop > kick > increment: stop -> IDLE with count=0; kick -> count=0; else count+1.
REQ-018 RUN with count==TIMEOUT-1, no kick, no stop -> EXPIRED at next edge with count=TIMEOUT; expired first high exactly TIMEOUT edges after the start edge, or TIMEOUT edges after the last kick edge.
REQ-019 Kick in the same cycle as count==TIMEOUT-1 SHALL prevent expiry; count -> 0.
REQ-020 EXPIRED: count holds at TIMEOUT; start, kick, stop ignored; clear=1 -> IDLE with count=0.
REQ-021 count SHALL never exceed TIMEOUT and never wrap.
REQ-022 running = (state==RUN); expired = (state==EXPIRED).

Reset
REQ-023 rst high SHALL immediately force IDLE, count=0, running=0, expired=0, warn=0, independent of clk.
REQ-024 Reset in mid-RUN or EXPIRED SHALL discard all progress; first start after rst deasserts behaves as from power-up.
REQ-025 Inputs SHALL be ignored while rst is high; the first edge after deassertion samples inputs normally.

Configuration
REQ-026 Macro WATCHDOG_WARN_EN SHALL control the warning feature.
REQ-027 With WATCHDOG_WARN_EN defined: warn = RUN and count >= TIMEOUT-WARN_MARGIN; warn deasserts on kick, stop, or expiry.
REQ-028 Without WATCHDOG_WARN_EN: warn port SHALL remain present and be tied 0; no warn comparison logic synthesized.

Verification
REQ-029 TIMEOUT=20: rst released, start 1 cycle, no kick -> running 1 for 20 cycles, count 0..19, then expired=1 with count=20, held 50 cycles.
REQ-030 TIMEOUT=20: start, kick every 15 cycles for 200 cycles -> expired stays 0 and count max 14.
REQ-031 TIMEOUT=20: kick coincident with count==19 -> count=0 next edge, expired 0; stop and kick together at count=7 -> IDLE, count=0.
REQ-032 In EXPIRED: start/kick/stop pulses -> no change; clear -> IDLE, count=0; start -> new 20-cycle expiry.
REQ-033 rst asserted asynchronously at count=12 in RUN and again in EXPIRED -> outputs zero before the next clk edge; IDLE after release.
REQ-034 WARN_MARGIN=4, macro defined: warn rises at count=16, falls on expiry or kick; macro undefined: warn constantly 0.
